exception_controller: RTL
=========================

EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 6, meaning program-counter width.
REQ-002 SHALL have parameter HANDLER_ADDR, default 6'd48, meaning exception-handler entry PC.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 3, meaning number of cycles the pipeline flush is held (legal range 1..7).
REQ-004 SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-006 SHALL have port exc_cause, input, 3, meaning cause code from the exception detector; 0 means none, 1..4 are defined causes.
REQ-007 SHALL have port exc_pc, input, PC_WIDTH, meaning faulting-instruction PC from the detector.
REQ-008 SHALL have port eret, input, 1, meaning one-cycle return-from-exception request from the handler.
REQ-009 SHALL have port flush, output, 3, meaning flush enables {EX/MEM, ID/EX, IF/ID}.
REQ-010 SHALL have port pc_sel, output, 1, meaning use pc_target as next PC.
REQ-011 SHALL have port pc_target, output, PC_WIDTH, meaning redirect PC.
REQ-012 SHALL have port exc_clear, output, 1, meaning one-cycle pulse clearing the detector's latched cause.
REQ-013 SHALL have port epc, output, PC_WIDTH, meaning saved exception PC.
REQ-014 SHALL have port cause, output, 3, meaning saved cause code.
REQ-015 SHALL have port in_handler, output, 1, meaning handler is executing.
REQ-016 SHALL have port exc_count, output, 8, meaning saturating count of accepted exceptions.

Function
REQ-017 SHALL implement FSM states IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
REQ-018 In IDLE, at a rising edge with exc_cause != 0, SHALL latch epc <= exc_pc and cause <= exc_cause, increment exc_count (saturate at 255), and go to FLUSH.
REQ-019 In FLUSH, SHALL drive flush = 3'b111 for exactly FLUSH_CYCLES consecutive cycles using an internal down-counter, then go to REDIRECT.
REQ-020 In REDIRECT (one cycle), SHALL drive pc_sel = 1, pc_target = HANDLER_ADDR, exc_clear = 1, then go to HANDLER.
REQ-021 In HANDLER, SHALL hold in_handler = 1 until eret = 1, then go to RETURN.
REQ-022 In RETURN (one cycle), SHALL drive pc_sel = 1, pc_target = epc + 1 (mod 2^PC_WIDTH, wrap 63 -> 0 at default width), flush = 3'b001, then go to IDLE.
REQ-023 Outside the states named in REQ-019 to REQ-022, SHALL drive flush = 0, pc_sel = 0, pc_target = 0, exc_clear = 0; in_handler SHALL be 0 except in HANDLER.
REQ-024 A nonzero exc_cause SHALL be ignored in every state except IDLE; epc/cause SHALL NOT be overwritten (no nesting).
REQ-025 eret SHALL be ignored in every state except HANDLER.
REQ-026 In IDLE, simultaneous nonzero exc_cause and eret: the exception SHALL be taken; eret is ignored.
REQ-027 Cause codes 5..7 SHALL be accepted and recorded unchanged.
REQ-028 Latency: exception sampled at edge N -> flush high for cycles N+1..N+FLUSH_CYCLES, pc_sel high in cycle N+FLUSH_CYCLES+1.
REQ-029 epc and cause SHALL hold their values after RETURN until the next accepted exception.
REQ-030 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-031 On rst = 1 at a rising edge, SHALL enter IDLE and clear epc, cause, exc_count, the flush counter and all outputs to 0, overriding any state, including mid-FLUSH and HANDLER.
REQ-032 rst SHALL have priority over exc_cause and eret in the same cycle.

Structure
REQ-033 Cause code constants (NONE=0, OPCODE=1, FUNCT=2, REGADDR=3, OVERFLOW=4) and the FSM state encoding SHALL live in a shared package used by this block and the detector.
REQ-034 SHALL be one flat module; no sub-module is required.

Verification
REQ-035 exc_cause=4, exc_pc=6'd10 for one cycle in IDLE -> flush=111 for 3 cycles, then pc_sel=1/pc_target=48/exc_clear=1 for one cycle, epc=10, cause=4, in_handler=1.
REQ-036 From REQ-035 end state, eret pulse -> one cycle pc_sel=1, pc_target=11, flush=001; then IDLE, all strobes 0, epc still 10.
REQ-037 exc_pc=6'd63, cause=1, then eret -> return pc_target=0 (wrap).
REQ-038 exc_cause=2 asserted during HANDLER -> ignored; epc/cause unchanged; exc_count unchanged.
REQ-039 rst asserted in 2nd FLUSH cycle -> next cycle IDLE, flush=0, epc=0, cause=0, exc_count=0.
REQ-040 256 back-to-back exception/eret sequences -> exc_count saturates at 255; eret in IDLE together with exc_cause=3 -> exception taken.

Source files
------------

// File: rtl/exception_controller_pkg.sv
// Shared exception constants: cause codes and controller FSM encoding,
// used by both the exception detector and the exception controller.
package exception_controller_pkg;

    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_OPCODE   = 3'd1;
    localparam logic [2:0] CAUSE_FUNCT    = 3'd2;
    localparam logic [2:0] CAUSE_REGADDR  = 3'd3;
    localparam logic [2:0] CAUSE_OVERFLOW = 3'd4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_FLUSH    = 3'd1;
    localparam state_t ST_REDIRECT = 3'd2;
    localparam state_t ST_HANDLER  = 3'd3;
    localparam state_t ST_RETURN   = 3'd4;

    localparam logic [2:0] FLUSH_ALL   = 3'b111;
    localparam logic [2:0] FLUSH_IF_ID = 3'b001;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/exception_controller.sv
// Non-nesting exception controller: flushes the pipeline, redirects to the
// handler, and returns to the instruction after the faulting PC on eret.
module exception_controller
    import exception_controller_pkg::*;
#(
    parameter int                  PC_WIDTH     = 6,
    parameter logic [PC_WIDTH-1:0] HANDLER_ADDR = 6'd48,
    parameter int                  FLUSH_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          exc_cause,
    input  logic [PC_WIDTH-1:0] exc_pc,
    input  logic                eret,
    output logic [2:0]          flush,
    output logic                pc_sel,
    output logic [PC_WIDTH-1:0] pc_target,
    output logic                exc_clear,
    output logic [PC_WIDTH-1:0] epc,
    output logic [2:0]          cause,
    output logic                in_handler,
    output logic [7:0]          exc_count
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t              state_reg;
    logic [2:0]          flush_cnt_reg;
    logic [PC_WIDTH-1:0] epc_reg;
    logic [2:0]          cause_reg;
    logic [7:0]          exc_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            flush_cnt_reg <= 3'd0;
            epc_reg       <= '0;
            cause_reg     <= CAUSE_NONE;
            exc_count_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // An exception wins over a stray eret arriving in the same cycle.
                    if (exc_cause != CAUSE_NONE) begin
                        epc_reg       <= exc_pc;
                        cause_reg     <= exc_cause;
                        exc_count_reg <= sat_inc8(exc_count_reg);
                        flush_cnt_reg <= FLUSH_INIT;
                        state_reg     <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_reg == 3'd0) begin
                        state_reg <= ST_REDIRECT;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - 3'd1;
                    end
                end
                ST_REDIRECT: state_reg <= ST_HANDLER;
                ST_HANDLER: begin
                    if (eret) begin
                        state_reg <= ST_RETURN;
                    end
                end
                ST_RETURN: state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode from registered state only, so no input reaches an output.
    always_comb begin
        flush      = 3'b000;
        pc_sel     = 1'b0;
        pc_target  = '0;
        exc_clear  = 1'b0;
        in_handler = 1'b0;
        case (state_reg)
            ST_FLUSH: flush = FLUSH_ALL;
            ST_REDIRECT: begin
                pc_sel    = 1'b1;
                pc_target = HANDLER_ADDR;
                exc_clear = 1'b1;
            end
            ST_HANDLER: in_handler = 1'b1;
            ST_RETURN: begin
                pc_sel    = 1'b1;
                pc_target = epc_reg + PC_WIDTH'(1);
                flush     = FLUSH_IF_ID;
            end
            default: ;
        endcase
    end

    assign epc       = epc_reg;
    assign cause     = cause_reg;
    assign exc_count = exc_count_reg;

endmodule
